clk_rate_ctrl: RTL and testbench

Run-time rate controller for the board clock-divider resource. It takes the 50 MHz board clock and produces one 50 %-duty divided clock and a matching one-cycle tick. The rate is chosen from five presets: div-by-2, 10 Hz, 1 Hz, 0.5 Hz and the LCD rate. Rate changes are requested through a req/ack handshake and take effect only at a full-period boundary, so the output clock never has a runt pulse.

---
 rtl/clk_rate_pkg.sv | 20 ++
 rtl/clk_rate_div.sv | 44 ++++
 rtl/clk_rate_ctrl.sv | 148 ++++++++++++++
 tb/tb_clk_rate_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rate_pkg.sv
// Shared rate codes, controller state encoding and default half-periods for clk_rate_ctrl.
package clk_rate_pkg;

  localparam logic [2:0] SEL_DIV2   = 3'd0;
  localparam logic [2:0] SEL_10HZ   = 3'd1;
  localparam logic [2:0] SEL_1HZ    = 3'd2;
  localparam logic [2:0] SEL_HALFHZ = 3'd3;
  localparam logic [2:0] SEL_LCD    = 3'd4;
  localparam logic [2:0] SEL_MAX    = 3'd4;

  // Half-periods in 50 MHz input clock cycles.
  localparam int unsigned DEF_HALF_DIV2   = 1;
  localparam int unsigned DEF_HALF_10HZ   = 2500000;
  localparam int unsigned DEF_HALF_1HZ    = 25000000;
  localparam int unsigned DEF_HALF_HALFHZ = 50000000;
  localparam int unsigned DEF_HALF_LCD    = 40000;

  typedef enum logic [1:0] {StIdle, StPend, StAck} state_e;

endpackage

// File: rtl/clk_rate_div.sv
// Phase counter and toggle flop: produces a 50%-duty clock, its rising-edge tick and the
// end-of-period boundary strobe. load_zero forces the start of a fresh low phase.
module clk_rate_div #(
  parameter int unsigned CNT_W = 27
) (
  input  logic             inclock,
  input  logic             reset,
  input  logic [CNT_W-1:0] half,
  input  logic             load_zero,
  output logic             outclock,
  output logic             tick,
  output logic             boundary
);

  logic [CNT_W-1:0] cnt_q;
  logic             out_q;
  logic             tick_q;
  logic             at_end;

  assign at_end   = (cnt_q == half - CNT_W'(1));
  assign boundary = at_end & out_q;
  assign outclock = out_q;
  assign tick     = tick_q;

  always_ff @(posedge inclock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else if (load_zero) begin
      cnt_q  <= '0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else if (at_end) begin
      cnt_q  <= '0;
      out_q  <= ~out_q;
      tick_q <= ~out_q;
    end else begin
      cnt_q  <= cnt_q + CNT_W'(1);
      tick_q <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_rate_ctrl.sv
// Run-time rate controller: req/ack rate selection applied only at full-period boundaries.
// Optional CLK_RATE_GATE_EN adds a run input that stops the divided clock at a boundary.
module clk_rate_ctrl
  import clk_rate_pkg::*;
#(
  parameter int unsigned HALF_DIV2   = DEF_HALF_DIV2,
  parameter int unsigned HALF_10HZ   = DEF_HALF_10HZ,
  parameter int unsigned HALF_1HZ    = DEF_HALF_1HZ,
  parameter int unsigned HALF_HALFHZ = DEF_HALF_HALFHZ,
  parameter int unsigned HALF_LCD    = DEF_HALF_LCD,
  parameter int unsigned RESET_SEL   = 2,
  parameter int unsigned CNT_W       = 27
) (
  input  logic       inclock,
  input  logic       reset,
`ifdef CLK_RATE_GATE_EN
  input  logic       run,
`endif
  input  logic       sel_req,
  input  logic [2:0] sel,
  output logic       sel_ack,
  output logic       sel_err,
  output logic       busy,
  output logic [2:0] cur_sel,
  output logic       outclock,
  output logic       tick
);

  function automatic logic [CNT_W-1:0] half_of(input logic [2:0] s);
    case (s)
      SEL_DIV2:   half_of = CNT_W'(HALF_DIV2);
      SEL_10HZ:   half_of = CNT_W'(HALF_10HZ);
      SEL_1HZ:    half_of = CNT_W'(HALF_1HZ);
      SEL_HALFHZ: half_of = CNT_W'(HALF_HALFHZ);
      default:    half_of = CNT_W'(HALF_LCD);
    endcase
  endfunction

  localparam logic [2:0]       RstSel  = 3'(RESET_SEL);
  localparam logic [CNT_W-1:0] HalfRst = half_of(RstSel);

  state_e           state_q, state_d;
  logic [2:0]       cur_sel_q, cur_sel_d;
  logic [2:0]       pend_sel_q, pend_sel_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] half_q;
  logic             boundary;
  logic             apply;
  logic             hold;
  logic             load_chg;

`ifdef CLK_RATE_GATE_EN
  logic stopped_q;

  always_ff @(posedge inclock or posedge reset) begin
    if (reset) begin
      stopped_q <= 1'b0;
    end else if (stopped_q) begin
      stopped_q <= ~run;
    end else if (boundary && !run) begin
      stopped_q <= 1'b1;
    end
  end

  // While stopped there is no boundary, so pending changes apply immediately.
  assign apply = boundary | stopped_q;
  assign hold  = stopped_q;
`else
  assign apply = boundary;
  assign hold  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cur_sel_d  = cur_sel_q;
    pend_sel_d = pend_sel_q;
    busy_d     = busy_q;
    err_d      = err_q;
    load_chg   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel_req) begin
          if (sel > SEL_MAX) begin
            err_d   = 1'b1;
            state_d = StAck;
          end else if (sel == cur_sel_q) begin
            state_d = StAck;
          end else begin
            pend_sel_d = sel;
            busy_d     = 1'b1;
            state_d    = StPend;
          end
        end
      end
      StPend: begin
        if (apply) begin
          cur_sel_d = pend_sel_q;
          load_chg  = 1'b1;
          state_d   = StAck;
        end
      end
      StAck: begin
        busy_d  = 1'b0;
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // half_q follows cur_sel_d so the first phase after a change already uses the new rate.
  always_ff @(posedge inclock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cur_sel_q  <= RstSel;
      pend_sel_q <= RstSel;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      half_q     <= HalfRst;
    end else begin
      state_q    <= state_d;
      cur_sel_q  <= cur_sel_d;
      pend_sel_q <= pend_sel_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      half_q     <= half_of(cur_sel_d);
    end
  end

  clk_rate_div #(
    .CNT_W(CNT_W)
  ) u_div (
    .inclock  (inclock),
    .reset    (reset),
    .half     (half_q),
    .load_zero(load_chg | hold),
    .outclock (outclock),
    .tick     (tick),
    .boundary (boundary)
  );

  assign sel_ack = (state_q == StAck);
  assign sel_err = err_q;
  assign busy    = busy_q;
  assign cur_sel = cur_sel_q;

endmodule

// File: tb/tb_clk_rate_ctrl.sv
// Directed bench for clk_rate_ctrl with shortened half-periods (1, 5, 50, 100, 8).
module tb_clk_rate_ctrl;

  logic       inclock;
  logic       reset;
  logic       run;
  logic       sel_req;
  logic [2:0] sel;
  logic       sel_ack;
  logic       sel_err;
  logic       busy;
  logic [2:0] cur_sel;
  logic       outclock;
  logic       tick;

  int checks;
  int failures;

  // Per-cycle monitor state, updated by step().
  int cyc, edge_cyc, last_high, last_low, min_phase, ticks, acks, tick_bad;
  logic prev_out;

  clk_rate_ctrl #(
    .HALF_DIV2  (1),
    .HALF_10HZ  (5),
    .HALF_1HZ   (50),
    .HALF_HALFHZ(100),
    .HALF_LCD   (8),
    .RESET_SEL  (2),
    .CNT_W      (27)
  ) dut (
    .inclock (inclock),
    .reset   (reset),
`ifdef CLK_RATE_GATE_EN
    .run     (run),
`endif
    .sel_req (sel_req),
    .sel     (sel),
    .sel_ack (sel_ack),
    .sel_err (sel_err),
    .busy    (busy),
    .cur_sel (cur_sel),
    .outclock(outclock),
    .tick    (tick)
  );

  initial inclock = 1'b0;
  always #5 inclock = ~inclock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_outclock"}, 32'(outclock), 0);
    check_eq({tag, "_tick"},     32'(tick),     0);
    check_eq({tag, "_cur_sel"},  32'(cur_sel),  2);
    check_eq({tag, "_sel_ack"},  32'(sel_ack),  0);
    check_eq({tag, "_sel_err"},  32'(sel_err),  0);
    check_eq({tag, "_busy"},     32'(busy),     0);
  endtask

  task automatic mon_init();
    cyc       = 0;
    edge_cyc  = 0;
    prev_out  = 1'b0;
    min_phase = 1000;
  endtask

  task automatic step();
    int len;
    @(posedge inclock);
    #1;
    cyc++;
    if (outclock !== prev_out) begin
      len = cyc - edge_cyc;
      if (prev_out) last_high = len;
      else last_low = len;
      if (len < min_phase) min_phase = len;
      edge_cyc = cyc;
    end
    if (tick !== (outclock && !prev_out)) tick_bad++;
    if (tick) ticks++;
    if (sel_ack) acks++;
    prev_out = outclock;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic wait_ack(input int max_cycles, output int at);
    at = -1;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (sel_ack) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int at;
    int a0;
    int t0;
    checks = 0; failures = 0;
    ticks = 0; acks = 0; tick_bad = 0; last_high = 0; last_low = 0;
    run = 1'b1; sel_req = 1'b0; sel = 3'd2;
    reset = 1'b1;
    @(posedge inclock);
    #1;
    check_reset_vals("reset");
    @(posedge inclock);
    #1;
    reset = 1'b0;
    mon_init();

    // Free-run at the reset rate: period 100, 50/50.
    run_to(400);
    check_eq("run_ticks", 32'(ticks), 4);
    check_eq("run_high", 32'(last_high), 50);
    check_eq("run_low", 32'(last_low), 50);
    check_eq("run_last_edge", 32'(edge_cyc), 400);
    check_eq("run_cur_sel", 32'(cur_sel), 2);

    // Change to LCD rate from mid high phase; applies at the fall at cycle 500.
    run_to(475);
    sel = 3'd4; sel_req = 1'b1; min_phase = 1000;
    step();
    sel_req = 1'b0;
    check_eq("lcd_busy", 32'(busy), 1);
    check_eq("lcd_no_early_ack", 32'(sel_ack), 0);
    wait_ack(200, at);
    check_eq("lcd_ack_cyc", 32'(at), 500);
    check_eq("lcd_err", 32'(sel_err), 0);
    check_eq("lcd_cur_sel", 32'(cur_sel), 4);
    step();
    check_eq("lcd_busy_clr", 32'(busy), 0);
    run_to(540);
    check_eq("lcd_low", 32'(last_low), 8);
    check_eq("lcd_high", 32'(last_high), 8);
    check_eq("lcd_min_phase", 32'(min_phase), 8);
    check_eq("lcd_rise_540", 32'(edge_cyc), 540);

    // Invalid code: rejected one cycle later, timing untouched.
    sel = 3'd6; sel_req = 1'b1;
    step();
    sel_req = 1'b0;
    check_eq("inv_ack", 32'(sel_ack), 1);
    check_eq("inv_err", 32'(sel_err), 1);
    check_eq("inv_cur_sel", 32'(cur_sel), 4);
    step();
    check_eq("inv_ack_clr", 32'(sel_ack), 0);
    check_eq("inv_err_clr", 32'(sel_err), 0);
    run_to(560);
    check_eq("inv_rise_556", 32'(edge_cyc), 556);
    check_eq("inv_high", 32'(last_high), 8);
    check_eq("inv_low", 32'(last_low), 8);

    // Held request with sel toggling while busy: first code only, one ack.
    a0 = acks;
    sel = 3'd2; sel_req = 1'b1;
    step();
    check_eq("hold_busy", 32'(busy), 1);
    sel = 3'd0;
    step();
    sel = 3'd7;
    step();
    sel = 3'd3;
    wait_ack(50, at);
    sel_req = 1'b0;
    check_eq("hold_ack_cyc", 32'(at), 564);
    check_eq("hold_cur_sel", 32'(cur_sel), 2);
    step(); step(); step();
    check_eq("hold_one_ack", 32'(acks - a0), 1);
    check_eq("hold_busy_clr", 32'(busy), 0);

    // Reset while pending: async return to reset values, no ack.
    run_to(620);
    sel = 3'd3; sel_req = 1'b1;
    step();
    sel_req = 1'b0;
    check_eq("rstp_busy", 32'(busy), 1);
    check_eq("rstp_out_high", 32'(outclock), 1);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("rstp");
    a0 = acks;
    @(posedge inclock);
    @(posedge inclock);
    #1;
    check_eq("rstp_held_ack", 32'(sel_ack), 0);
    reset = 1'b0;
    mon_init();
    run_to(60);
    check_eq("rstp_no_ack", 32'(acks - a0), 0);
    check_eq("rstp_cur_sel", 32'(cur_sel), 2);
    check_eq("rstp_first_rise", 32'(edge_cyc), 50);

    // Switch 2 -> 0: toggle every cycle, tick every other cycle.
    sel = 3'd0; sel_req = 1'b1;
    step();
    sel_req = 1'b0;
    wait_ack(200, at);
    check_eq("div2_ack_cyc", 32'(at), 100);
    check_eq("div2_cur_sel", 32'(cur_sel), 0);
    t0 = ticks;
    run_to(120);
    check_eq("div2_ticks", 32'(ticks - t0), 10);
    check_eq("div2_high", 32'(last_high), 1);
    check_eq("div2_low", 32'(last_low), 1);

`ifdef CLK_RATE_GATE_EN
    // Stop at the next boundary (cycle 122), then restart with a 1-cycle low phase.
    t0 = ticks;
    run = 1'b0;
    run_to(130);
    check_eq("gate_stopped_out", 32'(outclock), 0);
    check_eq("gate_stop_ticks", 32'(ticks - t0), 1);
    run = 1'b1;
    step();
    check_eq("gate_restart_low", 32'(outclock), 0);
    step();
    check_eq("gate_restart_high", 32'(outclock), 1);
    check_eq("gate_restart_tick", 32'(tick), 1);
`endif

    check_eq("tick_align", 32'(tick_bad), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
